// File: rtl/ahb_rr_burst_arbiter_pkg.sv
// Shared AHB transfer/burst types and arbiter state for the per-slave
// round-robin burst arbiter.
package ahb_rr_burst_arbiter_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  // Beats in a burst; 0 marks an undefined-length INCR burst.
  function automatic logic [7:0] burst_len(hburst_t b);
    case (b)
      BURST_SINGLE:              return 8'd1;
      BURST_WRAP4, BURST_INCR4:  return 8'd4;
      BURST_WRAP8, BURST_INCR8:  return 8'd8;
      BURST_WRAP16, BURST_INCR16: return 8'd16;
      default:                   return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_burst_arbiter_if.sv
// Request/grant bundle between the masters' request side and one slave's
// arbiter, plus the arbiter state for observation.
//
// Handshake: hreq[m] is a level held by master m until it no longer needs the
// slave; hgrant/hmaster change only on clock edges. A beat is accepted in any
// cycle where hready=1 and htrans is NONSEQ or SEQ; IDLE/BUSY or hready=0
// cycles transfer nothing.
interface ahb_rr_burst_arbiter_if #(
  parameter int MASTER_NUM = 4,
  parameter int MASTER_BIT = $clog2(MASTER_NUM)
) ();

  logic [MASTER_NUM-1:0]              hreq;
  ahb_rr_burst_arbiter_pkg::htrans_t  htrans;
  ahb_rr_burst_arbiter_pkg::hburst_t  hburst;
  logic                               hready;
  logic [MASTER_NUM-1:0]              hgrant;
  logic [MASTER_BIT-1:0]              hmaster;
  logic                               hsel;
  logic                               hlast;
  ahb_rr_burst_arbiter_pkg::arb_state_t state;

  modport master (
    output hreq, htrans, hburst, hready,
    input  hgrant, hmaster, hsel, hlast, state
  );

  modport slave (
    input  hreq, htrans, hburst, hready,
    output hgrant, hmaster, hsel, hlast, state
  );

endinterface

// File: rtl/ahb_rr_burst_arbiter_rr_pick.sv
// Rotating first-set-bit search: finds the first request at or after ptr,
// wrapping around, via a double-width mask and a plain priority scan.
module ahb_rr_burst_arbiter_rr_pick #(
  parameter int MASTER_NUM = 4,
  parameter int MASTER_BIT = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [MASTER_BIT-1:0] ptr,
  output logic [MASTER_NUM-1:0] onehot,
  output logic [MASTER_BIT-1:0] index,
  output logic                  valid
);

  localparam int W2 = 2 * MASTER_NUM;

  logic [W2-1:0] dbl;
  logic [W2-1:0] keep;
  logic [W2-1:0] masked;

  // Upper copy covers the wrap-around part of the search.
  assign dbl    = {req, req};
  assign keep   = ~((W2'(1) << ptr) - W2'(1));
  assign masked = dbl & keep;

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = W2 - 1; i >= 0; i--) begin
      if (masked[i]) begin
        valid = 1'b1;
        index = MASTER_BIT'(i % MASTER_NUM);
      end
    end
    onehot = valid ? (MASTER_NUM'(1) << index) : '0;
  end

endmodule

// File: rtl/ahb_rr_burst_arbiter.sv
// Per-slave round-robin arbiter that holds ownership for a whole burst and
// caps undefined-length INCR bursts when other masters are waiting.
module ahb_rr_burst_arbiter
  import ahb_rr_burst_arbiter_pkg::*;
#(
  parameter int MASTER_NUM     = 4,
  parameter int MASTER_BIT     = $clog2(MASTER_NUM),
  parameter int INCR_MAX_BEATS = 16
) (
  input logic              hclk,
  input logic              hreset_n,
  ahb_rr_burst_arbiter_if.slave bus
);

  localparam logic [7:0] INCR_CAP = 8'(INCR_MAX_BEATS);

  arb_state_t            state;
  logic [MASTER_BIT-1:0] ptr;
  logic [MASTER_BIT-1:0] owner;
  logic [MASTER_NUM-1:0] grant;
  logic [7:0]            cnt;
  hburst_t               burst_reg;

  logic [MASTER_BIT-1:0] own_next;
  logic [MASTER_BIT-1:0] pick_ptr;
  logic [MASTER_BIT-1:0] pick_idx;
  logic [MASTER_NUM-1:0] pick_oh;
  logic                  pick_valid;

  logic       nonseq_acc, seq_acc, beat_acc, started, in_burst;
  logic       owner_req, others_req;
  logic [7:0] cur_limit, new_cnt;
  logic       rel_fixed, rel_drop, rel_cap, rel_none, rel_any;

  assign own_next = (owner == MASTER_BIT'(MASTER_NUM - 1)) ? '0 : owner + MASTER_BIT'(1);
  // On release the search restarts just past the outgoing owner.
  assign pick_ptr = (state == ST_OWNED) ? own_next : ptr;

  ahb_rr_burst_arbiter_rr_pick #(
    .MASTER_NUM (MASTER_NUM),
    .MASTER_BIT (MASTER_BIT)
  ) u_pick (
    .req    (bus.hreq),
    .ptr    (pick_ptr),
    .onehot (pick_oh),
    .index  (pick_idx),
    .valid  (pick_valid)
  );

  assign started    = (cnt != 8'd0);
  assign nonseq_acc = bus.hready && (bus.htrans == TRANS_NONSEQ);
  assign seq_acc    = bus.hready && (bus.htrans == TRANS_SEQ);
  assign beat_acc   = nonseq_acc || (seq_acc && started);
  assign in_burst   = started || nonseq_acc;
  assign owner_req  = |(bus.hreq & grant);
  assign others_req = |(bus.hreq & ~grant);

  // A NONSEQ beat defines the burst it opens, so its own type sets the limit.
  assign cur_limit = nonseq_acc ? burst_len(bus.hburst) : burst_len(burst_reg);
  assign new_cnt   = nonseq_acc ? 8'd1 :
                     (seq_acc && started && cnt != 8'hFF) ? cnt + 8'd1 : cnt;

  assign rel_fixed = beat_acc && (cur_limit != 8'd0) && (new_cnt == cur_limit);
  assign rel_drop  = in_burst && (cur_limit == 8'd0) && !owner_req && bus.hready;
  assign rel_cap   = beat_acc && (cur_limit == 8'd0) && (new_cnt >= INCR_CAP) && others_req;
  assign rel_none  = !in_burst && !owner_req;
  assign rel_any   = (state == ST_OWNED) && (rel_fixed || rel_drop || rel_cap || rel_none);

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      grant     <= '0;
      cnt       <= '0;
      burst_reg <= BURST_SINGLE;
    end else if (state == ST_IDLE || rel_any) begin
      if (rel_any) ptr <= own_next;
      cnt <= '0;
      if (pick_valid) begin
        state <= ST_OWNED;
        grant <= pick_oh;
        owner <= pick_idx;
      end else begin
        state <= ST_IDLE;
        grant <= '0;
      end
    end else begin
      cnt <= new_cnt;
      if (nonseq_acc) burst_reg <= bus.hburst;
    end
  end

  assign bus.hgrant  = grant;
  assign bus.hmaster = owner;
  assign bus.hsel    = |grant;
  assign bus.hlast   = (state == ST_OWNED) && (rel_fixed || rel_cap);
  assign bus.state   = state;

endmodule
